// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-master byte-serial memory bus arbiter.
// Holds the sequencer states, master ids, memory map and the round-robin pick rule.
package mem_bus_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCESS  = 3'd1,
        RECOVER = 3'd2,
        DONE    = 3'd3,
        ERR     = 3'd4
    } state_e;

    typedef enum logic {
        MST_IF = 1'b0,
        MST_DM = 1'b1
    } master_e;

    localparam logic [31:0] IMEM_BASE   = 32'h0000_0000;
    localparam logic [31:0] DMEM_BASE   = 32'h0010_0000;
    localparam int unsigned REGION_SIZE = 4096;

    // A lone requester always wins; on a tie the master that was not served last wins.
    function automatic master_e rr_pick(input logic req_if, input logic req_dm,
                                        input master_e last_grant);
        master_e pick;
        if (req_if && req_dm) begin
            pick = (last_grant == MST_DM) ? MST_IF : MST_DM;
        end else if (req_dm) begin
            pick = MST_DM;
        end else begin
            pick = MST_IF;
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant. The last_grant history only moves when the
// consumer accepts a grant, so a grant that is not taken does not rotate priority.
module rr_arbiter2
    import mem_bus_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    req_if,
    input  logic    req_dm,
    input  logic    accept,
    output logic    grant_valid,
    output master_e grant_mst
);

    master_e last_grant_q;
    master_e last_grant_d;

    // Grant decode and history update.
    always_comb begin
        grant_valid = req_if | req_dm;
        grant_mst   = rr_pick(req_if, req_dm, last_grant_q);
        if (accept) begin
            last_grant_d = grant_mst;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // History register; DM counts as last served out of reset so IF wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= MST_DM;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one byte-wide memory bus between the fetch and load/store masters, moving
// each 32-bit word as four little-endian byte transfers with a per-byte timeout.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 32,
    parameter int WORD_BYTES    = 4,
    parameter int TIMEOUT       = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             if_req,
    input  logic [ADDRESS_WIDTH-1:0]         if_addr,
    output logic [DATA_WIDTH*WORD_BYTES-1:0] if_rdata,
    output logic                             if_ready,
    output logic                             if_err,
    input  logic                             dm_req,
    input  logic                             dm_we,
    input  logic [ADDRESS_WIDTH-1:0]         dm_addr,
    input  logic [DATA_WIDTH*WORD_BYTES-1:0] dm_wdata,
    output logic [DATA_WIDTH*WORD_BYTES-1:0] dm_rdata,
    output logic                             dm_ready,
    output logic                             dm_err,
    output logic                             readMem,
    output logic                             writemem,
    output logic [ADDRESS_WIDTH-1:0]         addressBus,
    output logic [DATA_WIDTH-1:0]            dataBusIn,
    input  logic                             memDataReady,
    input  logic [DATA_WIDTH-1:0]            dataBusOut
);

    localparam int WORD_W = DATA_WIDTH * WORD_BYTES;
    localparam int K_W    = $clog2(WORD_BYTES);
    localparam int CNT_W  = $clog2(TIMEOUT);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(WORD_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e                       state_q, state_d;
    logic [K_W-1:0]               k_q, k_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [ADDRESS_WIDTH-1:K_W]   addr_q, addr_d;
    logic                         we_q, we_d;
    logic [WORD_W-1:0]            wdata_q, wdata_d;
    master_e                      mst_q, mst_d;
    logic [WORD_W-1:0]            rbuf_q, rbuf_d;
    logic [WORD_W-1:0]            if_rdata_q, if_rdata_d;
    logic [WORD_W-1:0]            dm_rdata_q, dm_rdata_d;

    logic                         grant_valid_s;
    master_e                      grant_mst_s;
    logic                         accept_s;
    logic [WORD_W-1:0]            rword_s;
    logic [WORD_W-1:0]            done_word_s;
    logic [DATA_WIDTH-1:0]        wbyte_s;
    logic                         unused_addr_lsb_s;

    // Word address bits below the word boundary never reach the bus.
    assign unused_addr_lsb_s = ^{if_addr[K_W-1:0], dm_addr[K_W-1:0]};

    rr_arbiter2 u_rr (
        .clk         (clk),
        .rst         (rst),
        .req_if      (if_req),
        .req_dm      (dm_req),
        .accept      (accept_s),
        .grant_valid (grant_valid_s),
        .grant_mst   (grant_mst_s)
    );

    // Lane insert for the byte arriving now and lane select for the byte going out.
    always_comb begin
        rword_s = rbuf_q;
        wbyte_s = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (k_q == K_W'(i)) begin
                rword_s[i*DATA_WIDTH +: DATA_WIDTH] = dataBusOut;
                wbyte_s = wdata_q[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                rword_s[i*DATA_WIDTH +: DATA_WIDTH] = rbuf_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (we_q) begin
            done_word_s = {WORD_W{1'b0}};
        end else begin
            done_word_s = rword_s;
        end
    end

    // Sequencer next-state: grant in IDLE, then byte/recover pairs until DONE or ERR.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        mst_d      = mst_q;
        rbuf_d     = rbuf_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        accept_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid_s) begin
                    accept_s = 1'b1;
                    mst_d    = grant_mst_s;
                    k_d      = {K_W{1'b0}};
                    cnt_d    = {CNT_W{1'b0}};
                    state_d  = ACCESS;
                    if (grant_mst_s == MST_DM) begin
                        addr_d  = dm_addr[ADDRESS_WIDTH-1:K_W];
                        we_d    = dm_we;
                        wdata_d = dm_wdata;
                    end else begin
                        addr_d  = if_addr[ADDRESS_WIDTH-1:K_W];
                        we_d    = 1'b0;
                        wdata_d = {WORD_W{1'b0}};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (memDataReady) begin
                    cnt_d = {CNT_W{1'b0}};
                    if (we_q) begin
                        rbuf_d = rbuf_q;
                    end else begin
                        rbuf_d = rword_s;
                    end
                    if (k_q == K_LAST) begin
                        state_d = DONE;
                        if (mst_q == MST_DM) begin
                            dm_rdata_d = done_word_s;
                        end else begin
                            if_rdata_d = done_word_s;
                        end
                    end else begin
                        state_d = RECOVER;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ERR;
                    if (mst_q == MST_DM) begin
                        dm_rdata_d = {WORD_W{1'b0}};
                    end else begin
                        if_rdata_d = {WORD_W{1'b0}};
                    end
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            // k advances on leaving RECOVER so the address stays put while strobes are low.
            RECOVER: begin
                k_d     = k_q + {{(K_W-1){1'b0}}, 1'b1};
                state_d = ACCESS;
            end
            DONE: begin
                state_d = IDLE;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= {K_W{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            addr_q     <= {(ADDRESS_WIDTH-K_W){1'b0}};
            we_q       <= 1'b0;
            wdata_q    <= {WORD_W{1'b0}};
            mst_q      <= MST_IF;
            rbuf_q     <= {WORD_W{1'b0}};
            if_rdata_q <= {WORD_W{1'b0}};
            dm_rdata_q <= {WORD_W{1'b0}};
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            mst_q      <= mst_d;
            rbuf_q     <= rbuf_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign readMem    = (state_q == ACCESS) && !we_q;
    assign writemem   = (state_q == ACCESS) && we_q;
    assign addressBus = ((state_q == ACCESS) || (state_q == RECOVER)) ? {addr_q, k_q}
                                                                      : {ADDRESS_WIDTH{1'b0}};
    assign dataBusIn  = ((state_q == ACCESS) && we_q) ? wbyte_s : {DATA_WIDTH{1'b0}};
    assign if_ready   = (state_q == DONE) && (mst_q == MST_IF);
    assign dm_ready   = (state_q == DONE) && (mst_q == MST_DM);
    assign if_err     = (state_q == ERR)  && (mst_q == MST_IF);
    assign dm_err     = (state_q == ERR)  && (mst_q == MST_DM);
    assign if_rdata   = if_rdata_q;
    assign dm_rdata   = dm_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a byte-addressed memory model answers the bus, and a
// transaction-level reference predicts grant order, completion cycle, bytes and data.
module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata, addressBus;
    logic        if_ready, if_err, dm_ready, dm_err, readMem, writemem, memDataReady;
    logic [7:0]  dataBusIn, dataBusOut;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [7:0]  data;
    } bus_ev_t;

    typedef struct {
        bit          active;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          due;
        bit          exp_err;
    } txn_t;

    logic [7:0] mem [logic [31:0]];
    bus_ev_t    bus_log [$];
    int         wait_cycles = 0;
    int         cyc = 0;
    bit         model_last_dm = 1'b1;
    int         n_cmp = 0;
    int         n_mis = 0;

    mem_bus_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_rdata     (if_rdata),
        .if_ready     (if_ready),
        .if_err       (if_err),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_rdata     (dm_rdata),
        .dm_ready     (dm_ready),
        .dm_err       (dm_err),
        .readMem      (readMem),
        .writemem     (writemem),
        .addressBus   (addressBus),
        .dataBusIn    (dataBusIn),
        .memDataReady (memDataReady),
        .dataBusOut   (dataBusOut)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit mapped(input logic [31:0] a);
        return ((a - IMEM_BASE) < 32'(REGION_SIZE)) || ((a - DMEM_BASE) < 32'(REGION_SIZE));
    endfunction

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = 8'($urandom);
        return mem[a];
    endfunction

    function automatic int txn_latency(input bit is_err, input int w);
        return is_err ? (TO + 1) : (8 + 4 * w);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] base;
        if ($urandom_range(0, 7) == 0) begin
            base = 32'h0020_0000;
        end else if ($urandom_range(0, 1) == 1) begin
            base = DMEM_BASE;
        end else begin
            base = IMEM_BASE;
        end
        return base + 32'($urandom_range(0, 63));
    endfunction

    // Bus memory: answers mapped strobes after wait_cycles idle cycles; unmapped never answers.
    initial begin
        int wc;
        bit prev_ack;
        wc = 0;
        prev_ack = 1'b0;
        memDataReady = 1'b0;
        dataBusOut = 8'h00;
        forever begin
            @(negedge clk);
            if (prev_ack) check_eq("recover_strobe", 32'(readMem | writemem), 32'h0);
            prev_ack = 1'b0;
            if ((readMem || writemem) && mapped(addressBus) && (wc >= wait_cycles)) begin
                memDataReady = 1'b1;
                prev_ack = 1'b1;
                wc = 0;
                if (readMem) begin
                    dataBusOut = mem_rd(addressBus);
                    bus_log.push_back('{1'b0, addressBus, dataBusOut});
                end else begin
                    dataBusOut = 8'h00;
                    bus_log.push_back('{1'b1, addressBus, dataBusIn});
                end
            end else begin
                memDataReady = 1'b0;
                if (readMem || writemem) wc++;
                else wc = 0;
            end
        end
    end

    // Issue one request per selected master and check each completion against the model.
    task automatic serve(input bit use_if, input logic [31:0] ia, input bit use_dm,
                         input logic [31:0] da, input bit dwe, input logic [31:0] dwd,
                         input int w);
        txn_t        t [2];
        int          first, second, c0, budget;
        bit          p_rdy, p_err;
        logic [31:0] b, exp_word, got_word;
        bus_ev_t     ev;
        string       pfx;
        @(posedge clk); #1;
        bus_log.delete();
        wait_cycles = w;
        t[0] = '{use_if, 1'b0, ia, 32'h0, 0, !mapped({ia[31:2], 2'b00})};
        t[1] = '{use_dm, dwe, da, dwd, 0, !mapped({da[31:2], 2'b00})};
        if (use_if && use_dm) begin
            first  = model_last_dm ? 0 : 1;
            second = 1 - first;
        end else begin
            first  = use_dm ? 1 : 0;
            second = -1;
        end
        c0 = cyc;
        t[first].due = c0 + txn_latency(t[first].exp_err, w);
        if (second >= 0) t[second].due = t[first].due + 1 + txn_latency(t[second].exp_err, w);
        model_last_dm = (second >= 0) ? (second == 1) : (first == 1);
        if_addr = ia; if_req = use_if;
        dm_addr = da; dm_we = dwe; dm_wdata = dwd; dm_req = use_dm;
        budget = 400;
        while ((t[0].active || t[1].active) && budget > 0) begin
            @(posedge clk); #1;
            budget--;
            for (int m = 0; m < 2; m++) begin
                pfx      = (m == 0) ? "if" : "dm";
                p_rdy    = (m == 0) ? if_ready : dm_ready;
                p_err    = (m == 0) ? if_err : dm_err;
                got_word = (m == 0) ? if_rdata : dm_rdata;
                if ((p_rdy || p_err) && !t[m].active) begin
                    check_eq({pfx, "_spurious_pulse"}, {30'h0, p_rdy, p_err}, 32'h0);
                end else if (p_rdy || p_err) begin
                    check_eq({pfx, "_err_flag"}, 32'(p_err), 32'(t[m].exp_err));
                    check_eq({pfx, "_ready_flag"}, 32'(p_rdy), 32'(!t[m].exp_err));
                    check_eq({pfx, "_latency"}, 32'(cyc - c0), 32'(t[m].due - c0));
                    b = {t[m].addr[31:2], 2'b00};
                    if (t[m].exp_err || t[m].we) exp_word = 32'h0;
                    else exp_word = {mem_rd(b + 3), mem_rd(b + 2), mem_rd(b + 1), mem_rd(b)};
                    check_eq({pfx, "_rdata"}, got_word, exp_word);
                    if (t[m].exp_err) begin
                        check_eq({pfx, "_err_bytes"}, 32'(bus_log.size()), 32'h0);
                    end else begin
                        check_eq({pfx, "_byte_count"}, 32'(bus_log.size()), 32'd4);
                        for (int i = 0; i < 4 && bus_log.size() > 0; i++) begin
                            ev = bus_log.pop_front();
                            check_eq({pfx, "_bus_addr"}, ev.addr, b + 32'(i));
                            check_eq({pfx, "_bus_we"}, 32'(ev.we), 32'(t[m].we));
                            if (t[m].we) begin
                                check_eq({pfx, "_bus_wbyte"}, 32'(ev.data), (t[m].wdata >> (8 * i)) & 32'hFF);
                                mem[b + 32'(i)] = 8'((t[m].wdata >> (8 * i)) & 32'hFF);
                            end else begin
                                check_eq({pfx, "_bus_rbyte"}, 32'(ev.data), 32'(mem_rd(b + 32'(i))));
                            end
                        end
                    end
                    t[m].active = 1'b0;
                    if (m == 0) if_req = 1'b0;
                    else dm_req = 1'b0;
                end
            end
        end
        check_eq("serve_pending", {30'h0, t[1].active, t[0].active}, 32'h0);
        if_req = 1'b0;
        dm_req = 1'b0;
    endtask

    initial begin
        bit          ui, ud, dwe, any_pulse;
        int          sel, w, c0;
        logic [31:0] ia, da, wd;

        rst = 1'b1;
        if_req = 1'b0; if_addr = 32'h0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_eq("rst_if_rdata", if_rdata, 32'h0);
        check_eq("rst_dm_rdata", dm_rdata, 32'h0);
        check_eq("rst_if_ready", 32'(if_ready), 32'h0);
        check_eq("rst_if_err", 32'(if_err), 32'h0);
        check_eq("rst_dm_ready", 32'(dm_ready), 32'h0);
        check_eq("rst_dm_err", 32'(dm_err), 32'h0);
        check_eq("rst_readMem", 32'(readMem), 32'h0);
        check_eq("rst_writemem", 32'(writemem), 32'h0);
        check_eq("rst_addressBus", addressBus, 32'h0);
        check_eq("rst_dataBusIn", 32'(dataBusIn), 32'h0);

        // Simultaneous requests: IF, DM, then IF again.
        serve(1'b1, 32'h0000_0020, 1'b1, 32'h0010_0020, 1'b0, 32'h0, 0);
        serve(1'b1, 32'h0000_0024, 1'b1, 32'h0010_0024, 1'b1, 32'h1234_5678, 1);

        mem[32'h10] = 8'h11; mem[32'h11] = 8'h22; mem[32'h12] = 8'h33; mem[32'h13] = 8'h44;
        serve(1'b1, 32'h0000_0010, 1'b0, 32'h0, 1'b0, 32'h0, 0);
        check_eq("t1_if_rdata", if_rdata, 32'h4433_2211);

        serve(1'b0, 32'h0, 1'b1, 32'h0010_0004, 1'b1, 32'hDEAD_BEEF, 0);
        check_eq("t2_dm_rdata", dm_rdata, 32'h0);

        serve(1'b0, 32'h0, 1'b1, 32'h0020_0000, 1'b0, 32'h0, 0);
        check_eq("t4_dm_rdata", dm_rdata, 32'h0);
        serve(1'b1, 32'h0000_0100, 1'b0, 32'h0, 1'b0, 32'h0, 0);

        serve(1'b0, 32'h0, 1'b1, 32'h0010_0003, 1'b0, 32'h0, 2);

        // Reset during byte 2 of a DM read.
        @(posedge clk); #1;
        wait_cycles = 0;
        dm_addr = 32'h0010_0040; dm_we = 1'b0; dm_req = 1'b1;
        c0 = cyc;
        repeat (5) begin @(posedge clk); #1; end
        check_eq("t5_pre_readMem", 32'(readMem), 32'h1);
        check_eq("t5_pre_addr", addressBus, 32'h0010_0042);
        rst = 1'b1;
        dm_req = 1'b0;
        @(posedge clk); #1;
        check_eq("t5_readMem", 32'(readMem), 32'h0);
        check_eq("t5_writemem", 32'(writemem), 32'h0);
        check_eq("t5_addr", addressBus, 32'h0);
        any_pulse = dm_ready | dm_err;
        rst = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            any_pulse = any_pulse | dm_ready | dm_err | if_ready | if_err;
        end
        check_eq("t5_no_pulse", 32'(any_pulse), 32'h0);
        check_eq("t5_elapsed", 32'(cyc - c0), 32'd16);
        model_last_dm = 1'b1;
        serve(1'b0, 32'h0, 1'b1, 32'h0010_0040, 1'b0, 32'h0, 0);

        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 2);
            ui  = (sel != 1);
            ud  = (sel != 0);
            ia  = rand_addr();
            da  = rand_addr();
            dwe = 1'($urandom_range(0, 1));
            wd  = $urandom;
            w   = $urandom_range(0, 3);
            serve(ui, ia, ud, da, dwe, wd, w);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single 8-bit memory Bus (SPI instruction flash at 0x0000_0000–0x0000_0FFF, SRAM data memory at 0x0010_0000–0x0010_0FFF) between the instruction-fetch master and the load/store master.
- Each master issues 32-bit word requests.
- The arbiter grants round-robin and sequences four byte transfers, little-endian, over the bus.
- A per-byte timeout guards against unmapped addresses.
- Sits between the core's two memory ports and the Bus.

Parameters:
DATA_WIDTH, 8, bus byte width
ADDRESS_WIDTH, 32, address width
WORD_BYTES, 4, bytes per master word
TIMEOUT, 64, max cycles waiting for memDataReady per byte

Ports:
clk  in  1  clock
rst  in  1  reset
if_req  in  1  fetch request, held until if_ready or if_err
if_addr  in  32  fetch word address; bits [1:0] ignored
if_rdata  out  32  fetch data, valid with if_ready
if_ready  out  1  one-cycle completion pulse
if_err  out  1  one-cycle timeout pulse
dm_req  in  1  data request, held until dm_ready or dm_err
dm_we  in  1  1 = write, 0 = read
dm_addr  in  32  data word address; bits [1:0] ignored
dm_wdata  in  32  write data
dm_rdata  out  32  read data, valid with dm_ready
dm_ready  out  1  one-cycle completion pulse
dm_err  out  1  one-cycle timeout pulse
readMem  out  1  bus read strobe
writemem  out  1  bus write strobe
addressBus  out  32  bus byte address
dataBusIn  out  8  byte to bus
memDataReady  in  1  bus byte-complete
dataBusOut  in  8  byte from bus

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset:
  - FSM returns to IDLE; byte index k=0; timeout count=0.
  - last_grant=DM, so IF wins the first tie.
  - All outputs 0.
  - Reset mid-transaction: strobes low on the next edge; no ready/err pulse is issued.
- Bus outputs are decoded from registered state only. There is no combinational path from the if_*/dm_* inputs to the bus outputs.
- IDLE:
  - Strobes low; addressBus=0.
  - If only one request is high, grant it.
  - If both are high, grant the master not in last_grant.
  - On grant, latch addr[31:2], we (IF is always read), wdata and master id; update last_grant; go to ACCESS with k=0.
- ACCESS:
  - addressBus={addr[31:2],k[1:0]}.
  - readMem=~we, writemem=we; dataBusIn=wdata[8k+7:8k] on writes, else 0.
  - memDataReady=1: on reads, capture dataBusOut into byte lane k; clear the timeout count; if k==3 go to DONE, else k++ and go to RECOVER.
  - memDataReady=0: count++; if count reaches TIMEOUT-1 go to ERR.
- RECOVER: one cycle, strobes low, address held. Gives the SPI/SRAM a deassertion edge. Then go to ACCESS.
- DONE:
  - Pulse the granted master's ready for one cycle.
  - rdata holds the assembled word (0 for writes) and stays stable until that master's next grant.
  - Go to IDLE.
- ERR: pulse the granted master's err for one cycle; rdata=0; go to IDLE. A partially written word is not rolled back.
- Latency: with zero-wait memory, req sampled in IDLE at cycle 0 gives:
  - ACCESS at cycles 1, 3, 5, 7
  - RECOVER at cycles 2, 4, 6
  - ready at cycle 8
  - Each memory wait cycle adds 1.
- Back-to-back: the next grant is evaluated in the IDLE cycle following DONE/ERR. With both masters continuously requesting, grants alternate IF, DM, IF, …
- Dropping req mid-transaction is illegal. The arbiter completes the transfer and pulses ready anyway.
- A master must lower req in the cycle after it sees its ready/err, or it is treated as a new request.

Decomposition:
- Shared package/header mem_bus_pkg holds:
  - state encodings: IDLE, ACCESS, RECOVER, DONE, ERR
  - master ids: MST_IF, MST_DM
  - region constants: IMEM_BASE=32'h0000_0000, DMEM_BASE=32'h0010_0000, REGION_SIZE=4096
- One sub-module, rr_arbiter2: a two-requester round-robin grant with last_grant register, updated on an accept strobe.

Test Plan:
- IF-only read at 0x0000_0010; bus returns bytes 0x11,0x22,0x33,0x44 with zero wait -> addressBus sequence 0x10,0x11,0x12,0x13; if_rdata=32'h4433_2211; if_ready at cycle 8; readMem low in RECOVER cycles.
- DM write 32'hDEAD_BEEF to 0x0010_0004 -> writemem high with dataBusIn EF,BE,AD,DE at addresses 0x0010_0004–0x0010_0007; dm_ready once; dm_rdata=0.
- if_req and dm_req high together after reset, both held across two transactions -> IF granted first, DM second; third grant goes to IF.
- DM read at unmapped 0x0020_0000 with memDataReady stuck at 0 -> dm_err pulses after 64 ACCESS cycles; dm_rdata=0; FSM back in IDLE; next IF request is served normally.
- rst asserted during byte 2 of a DM read -> next cycle strobes=0, no dm_ready/dm_err; a fresh request afterwards completes correctly.
- dm_addr=0x0010_0003 (unaligned) with 2 wait cycles per byte -> bytes read from 0x0010_0000–0x0010_0003; dm_ready at cycle 16.
